// File: rtl/irda_tx.sv
// IrDA SIR transmitter: double-buffered byte intake, UART-style framing,
// and one registered IR pulse per 0-bit inside the baud generator's txir window.
module irda_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 baud_full,
   input  logic                 baud_txir,
   output logic                 baud_ena,
   output logic                 ir_tx,
   output logic                 busy
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_hold;
   logic                 r_hold_full;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic                 r_ir_tx;

   logic w_accept;
   logic w_load;
   logic w_shift;
   logic w_cnt_inc;
   logic w_cnt_clr;
   logic w_cur_bit;

   // Accept only into an empty holding register, so it can never collide with a load.
   assign w_accept = tx_valid && !r_hold_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cur_bit   = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (r_hold_full) begin
               w_load      = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_cur_bit = 1'b0;
            if (baud_full) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_cur_bit = r_shift[0];
            if (baud_full) begin
               w_shift = 1'b1;
               if (r_bit_cnt == DATA_LAST) begin
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = S_STOP;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (baud_full) begin
               if (r_bit_cnt == STOP_LAST) begin
                  // Chain straight into the next START when a byte is already waiting.
                  if (r_hold_full) begin
                     w_load      = 1'b1;
                     w_state_nxt = S_START;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_accept) begin
         r_hold      <= tx_data;
         r_hold_full <= 1'b1;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
      end else if (w_load) begin
         r_shift <= r_hold;
      end else if (w_shift) begin
         r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
      end
   end

   // bit_cnt doubles as the stop-bit counter, so every load must clear it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bit_cnt <= '0;
      end else if (w_load || w_cnt_clr) begin
         r_bit_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_ir_tx <= 1'b0;
      else      r_ir_tx <= (r_state != S_IDLE) && !w_cur_bit && baud_txir;
   end

   assign tx_ready = !r_hold_full;
   assign baud_ena = (r_state != S_IDLE);
   assign busy     = (r_state != S_IDLE);
   assign ir_tx    = r_ir_tx;

endmodule

// File: tb/tb_irda_tx.sv
// Directed bench for irda_tx: two instances (default and 7N2) each fed by a
// 16-clock baud generator model with a txir window on counts 7..9.
module tb_irda_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d1;
   logic [6:0] d2;
   logic       v1, v2;
   logic       rdy1, rdy2, ena1, ena2, ir1, ir2, busy1, busy2;
   logic       full1, full2, txir1, txir2;
   logic [3:0] g1_cnt, g2_cnt;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;

   logic [31:0] m;
   int hi, off, bl, rs, sc;
   int a0, a1, a2, w0, w1, w2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst) begin
      if (!rst)      g1_cnt <= 4'd0;
      else if (!ena1) g1_cnt <= 4'd0;
      else           g1_cnt <= g1_cnt + 4'd1;
   end
   always @(posedge clk or negedge rst) begin
      if (!rst)      g2_cnt <= 4'd0;
      else if (!ena2) g2_cnt <= 4'd0;
      else           g2_cnt <= g2_cnt + 4'd1;
   end
   assign full1 = (g1_cnt == 4'd15);
   assign full2 = (g2_cnt == 4'd15);
   assign txir1 = (g1_cnt >= 4'd7) && (g1_cnt <= 4'd9);
   assign txir2 = (g2_cnt >= 4'd7) && (g2_cnt <= 4'd9);

   irda_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
      .baud_full(full1), .baud_txir(txir1), .baud_ena(ena1), .ir_tx(ir1), .busy(busy1));

   irda_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
      .baud_full(full2), .baud_txir(txir2), .baud_ena(ena2), .ir_tx(ir2), .busy(busy2));

   task automatic send(input int which, input logic [7:0] b, output int acc, output int waits);
      int n = 0;
      @(negedge clk);
      if (which == 0) begin d1 = b; v1 = 1'b1; end
      else begin d2 = b[6:0]; v2 = 1'b1; end
      while (((which == 0) ? !rdy1 : !rdy2) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         total++; bad++;
         $display("FAIL send_timeout: tx_ready never rose for 0x%02h (waited %0d)", b, n);
      end
      @(posedge clk);
      #1;
      acc = cyc;
      waits = n;
      if (which == 0) v1 = 1'b0;
      else v2 = 1'b0;
   endtask

   // Index 0 is the first clock with busy high; a 0-bit in slot s shows ir_tx on 16s+8..16s+10.
   task automatic capture(input int which, input int ncyc, output logic [31:0] mask,
                          output int highs, output int offs, output int blen,
                          output int rises, output int startc);
      int   n = 0;
      logic b, ir, pb;
      mask = '0; highs = 0; offs = 0; blen = 0; rises = 0;
      @(negedge clk);
      while (!((which == 0) ? busy1 : busy2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL capture_timeout: busy never rose on dut%0d", which + 1);
      end
      startc = (which == 0) ? int'(g1_cnt) : int'(g2_cnt);
      pb = 1'b1;
      for (int i = 0; i < ncyc + 8; i++) begin
         if (i > 0) @(negedge clk);
         b  = (which == 0) ? busy1 : busy2;
         ir = (which == 0) ? ir1 : ir2;
         if (b) blen++;
         if (b && !pb) rises++;
         pb = b;
         if (ir) begin
            highs++;
            if ((i % 16) >= 8 && (i % 16) <= 10) mask[i / 16] = 1'b1;
            else offs++;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; v1 = 1'b1; d1 = 8'h00; v2 = 1'b0; d2 = 7'h00;
      repeat (3) @(negedge clk);
      total++; if (ir1 !== 1'b0)   begin bad++; $display("FAIL rst_ir: got %b want 0", ir1); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy1); end
      total++; if (ena1 !== 1'b0)  begin bad++; $display("FAIL rst_ena: got %b want 0", ena1); end
      total++; if (rdy1 !== 1'b1)  begin bad++; $display("FAIL rst_ready: got %b want 1", rdy1); end
      v1 = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (busy1 !== 1'b0 || rdy1 !== 1'b1) begin
         bad++; $display("FAIL rst_valid_ignored: busy=%b ready=%b want 0/1", busy1, rdy1);
      end
   endtask

   task automatic test_0x55;
      send(0, 8'h55, a0, w0);
      capture(0, 160, m, hi, off, bl, rs, sc);
      total++; if (m !== 32'h155) begin bad++; $display("FAIL p55_mask: got %h want 155", m); end
      total++; if (hi != 15 || off != 0) begin bad++; $display("FAIL p55_width: highs=%0d off=%0d want 15/0", hi, off); end
      total++; if (bl != 160 || rs != 0) begin bad++; $display("FAIL p55_busy: len=%0d rises=%0d want 160/0", bl, rs); end
      total++; if (sc != 0) begin bad++; $display("FAIL p55_start_cnt: got %0d want 0", sc); end
   endtask

   task automatic test_ff_00;
      send(0, 8'hFF, a0, w0);
      capture(0, 160, m, hi, off, bl, rs, sc);
      total++; if (m !== 32'h001 || hi != 3 || off != 0) begin
         bad++; $display("FAIL pFF: mask=%h highs=%0d off=%0d want 001/3/0", m, hi, off);
      end
      send(0, 8'h00, a0, w0);
      capture(0, 160, m, hi, off, bl, rs, sc);
      total++; if (m !== 32'h1FF || hi != 27 || off != 0) begin
         bad++; $display("FAIL p00: mask=%h highs=%0d off=%0d want 1ff/27/0", m, hi, off);
      end
      total++; if (ena1 !== 1'b0 || g1_cnt !== 4'd0) begin
         bad++; $display("FAIL p00_idle: ena=%b cnt=%0d want 0/0", ena1, g1_cnt);
      end
   endtask

   task automatic test_back_to_back;
      fork
         begin
            send(0, 8'hA5, a0, w0);
            send(0, 8'h3C, a1, w1);
         end
         capture(0, 320, m, hi, off, bl, rs, sc);
      join
      total++; if (w1 != 1 || a1 - a0 != 2) begin
         bad++; $display("FAIL b2b_ready_drop: waits=%0d gap=%0d want 1/2", w1, a1 - a0);
      end
      total++; if (bl != 320 || rs != 0) begin bad++; $display("FAIL b2b_busy: len=%0d rises=%0d want 320/0", bl, rs); end
      total++; if (m !== 32'h61CB5) begin bad++; $display("FAIL b2b_mask: got %h want 61cb5", m); end
      total++; if (hi != 30 || off != 0) begin bad++; $display("FAIL b2b_width: highs=%0d off=%0d want 30/0", hi, off); end
   endtask

   task automatic test_third_byte;
      fork
         begin
            send(0, 8'h01, a0, w0);
            send(0, 8'h80, a1, w1);
            send(0, 8'hC3, a2, w2);
         end
         capture(0, 480, m, hi, off, bl, rs, sc);
      join
      total++; if (a1 - a0 != 2) begin bad++; $display("FAIL third_gap2: got %0d want 2", a1 - a0); end
      total++; if (a2 - a0 != 162 || w2 != 159) begin
         bad++; $display("FAIL third_hold: gap=%0d waits=%0d want 162/159", a2 - a0, w2);
      end
      total++; if (m !== 32'h0793FDFD || hi != 63 || off != 0) begin
         bad++; $display("FAIL third_mask: mask=%h highs=%0d off=%0d want 0793fdfd/63/0", m, hi, off);
      end
      total++; if (bl != 480 || rs != 0) begin bad++; $display("FAIL third_busy: len=%0d rises=%0d want 480/0", bl, rs); end
   endtask

   task automatic test_reset_midframe;
      int n = 0;
      send(0, 8'h00, a0, w0);
      while (ir1 !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++; if (n >= 100) begin bad++; $display("FAIL mid_no_pulse: ir_tx never rose"); end
      #1 rst = 1'b0;
      #1;
      total++; if (ir1 !== 1'b0 || busy1 !== 1'b0 || ena1 !== 1'b0 || rdy1 !== 1'b1) begin
         bad++; $display("FAIL mid_async: ir=%b busy=%b ena=%b ready=%b want 0/0/0/1", ir1, busy1, ena1, rdy1);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (ir1 !== 1'b0 || busy1 !== 1'b0) begin
         bad++; $display("FAIL mid_after: ir=%b busy=%b want 0/0", ir1, busy1);
      end
      send(0, 8'h00, a0, w0);
      capture(0, 160, m, hi, off, bl, rs, sc);
      total++; if (m !== 32'h1FF || hi != 27 || off != 0 || sc != 0) begin
         bad++; $display("FAIL mid_resend: mask=%h highs=%0d off=%0d start=%0d want 1ff/27/0/0", m, hi, off, sc);
      end
   endtask

   task automatic test_7n2;
      send(1, 8'h00, a0, w0);
      capture(1, 160, m, hi, off, bl, rs, sc);
      total++; if (m !== 32'h0FF || hi != 24 || off != 0) begin
         bad++; $display("FAIL n72_mask: mask=%h highs=%0d off=%0d want 0ff/24/0", m, hi, off);
      end
      total++; if (bl != 160 || rs != 0 || sc != 0) begin
         bad++; $display("FAIL n72_len: len=%0d rises=%0d start=%0d want 160/0/0", bl, rs, sc);
      end
      total++; if (ena2 !== 1'b0 || g2_cnt !== 4'd0) begin
         bad++; $display("FAIL n72_idle: ena=%b cnt=%0d want 0/0", ena2, g2_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_0x55;
      test_ff_00;
      test_back_to_back;
      test_third_byte;
      test_reset_midframe;
      test_7n2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
